rf_wb_arbiter: RTL

Write-back scheduler for the thread register file. It shares the single register-file write port among `NUM_REQ` write-back sources: ALU, load unit and SIMD unit. It arbitrates round-robin and sequences 56-bit SIMD results as two consecutive 28-bit register writes. It sits between the execute/load stages and the register file's `wen`/`dest_sel`/`data_in`/`isSIMD` inputs.

---
 rtl/rf_wb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/rf_wb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, reserved register indices and FSM states for the write-back arbiter
package rf_wb_pkg;

   localparam int RF_ADDR_W = 4;
   localparam int RF_DATA_W = 28;
   localparam int ZERO_REG  = 0;
   localparam int LAST_REG  = 15;

   typedef enum logic {
      IDLE = 1'b0,
      HI   = 1'b1
   } wb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick; the rotating pointer is owned by the parent
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic found;

   // Scan from the pointer upward with wrap; the first requester seen wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         int idx;
         idx = (int'(ptr_i) + off) % NUM_REQ;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-back scheduler; RF_WB_PERF_EN adds a conflict counter
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_dest,
   input  logic [NUM_REQ-1:0]            req_simd,
   input  logic [NUM_REQ*2*DATA_W-1:0]   req_data,
   output logic                          rf_wen,
   output logic [ADDR_W-1:0]             rf_dest_sel,
   output logic [DATA_W-1:0]             rf_data,
   output logic                          rf_is_simd,
   output logic                          busy
`ifdef RF_WB_PERF_EN
   ,output logic [15:0]                  conflict_cnt
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   wb_state_e            state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 rf_wen_q, rf_wen_d;
   logic [ADDR_W-1:0]    rf_dest_q, rf_dest_d;
   logic [DATA_W-1:0]    rf_data_q, rf_data_d;
   logic                 rf_simd_q, rf_simd_d;
   logic [ADDR_W-1:0]    hi_dest_q, hi_dest_d;
   logic [DATA_W-1:0]    hi_data_q, hi_data_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [PTR_W-1:0]     win_idx;
   logic [ADDR_W-1:0]    sel_dest;
   logic [2*DATA_W-1:0]  sel_data;
   logic                 sel_simd;
   logic                 pair;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt)
   );

   always_comb begin
      win_idx  = '0;
      sel_dest = '0;
      sel_data = '0;
      sel_simd = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            win_idx  = PTR_W'(i);
            sel_dest = req_dest[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*2*DATA_W +: 2*DATA_W];
            sel_simd = req_simd[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      rf_wen_d  = 1'b0;
      rf_dest_d = rf_dest_q;
      rf_data_d = rf_data_q;
      rf_simd_d = rf_simd_q;
      hi_dest_d = hi_dest_q;
      hi_data_d = hi_data_q;
      req_ready = '0;
      pair      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = rst ? '0 : gnt;
            if (|(req_valid & req_ready)) begin
               rr_ptr_d  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
               // Register 0 reads as zero, so its write is swallowed after the handshake.
               rf_wen_d  = (sel_dest != ADDR_W'(ZERO_REG));
               rf_dest_d = sel_dest;
               rf_data_d = sel_data[DATA_W-1:0];
               // No register above the last one: the high lane is dropped instead of wrapping.
               pair      = sel_simd && (sel_dest != ADDR_W'(LAST_REG));
               rf_simd_d = pair;
               if (pair) begin
                  hi_dest_d = sel_dest + ADDR_W'(1);
                  hi_data_d = sel_data[2*DATA_W-1:DATA_W];
                  state_d   = HI;
               end
            end
         end
         HI: begin
            rf_wen_d  = 1'b1;
            rf_dest_d = hi_dest_q;
            rf_data_d = hi_data_q;
            rf_simd_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         rf_wen_q  <= 1'b0;
         rf_dest_q <= '0;
         rf_data_q <= '0;
         rf_simd_q <= 1'b0;
         hi_dest_q <= '0;
         hi_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         rf_wen_q  <= rf_wen_d;
         rf_dest_q <= rf_dest_d;
         rf_data_q <= rf_data_d;
         rf_simd_q <= rf_simd_d;
         hi_dest_q <= hi_dest_d;
         hi_data_q <= hi_data_d;
      end
   end

   assign rf_wen      = rf_wen_q;
   assign rf_dest_sel = rf_dest_q;
   assign rf_data     = rf_data_q;
   assign rf_is_simd  = rf_simd_q;
   assign busy        = (state_q == HI) || rf_wen_q;

`ifdef RF_WB_PERF_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   // Any valid requester left waiting this cycle, which covers every valid in HI.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (|(req_valid & ~req_ready) && (conflict_cnt_q != 16'hFFFF))
         conflict_cnt_d = conflict_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) conflict_cnt_q <= '0;
      else     conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
